piece_queue: RTL and testbench

//  Next-piece preview queue sitting directly downstream of the free-running piece RNG.

---
 rtl/piece_pkg.sv | 17 +
 rtl/piece_fifo.sv | 47 ++++
 rtl/piece_queue.sv | 84 ++++++++
 tb/tb_piece_queue.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/piece_pkg.sv
// Shared piece codes and queue-state encoding for the next-piece preview queue.
// Pure declarations: no latency, no backpressure.
package piece_pkg;

  localparam int PIECE_W = 2;

  localparam logic [PIECE_W-1:0] PIECE_I = 2'd0;
  localparam logic [PIECE_W-1:0] PIECE_O = 2'd1;
  localparam logic [PIECE_W-1:0] PIECE_T = 2'd2;
  localparam logic [PIECE_W-1:0] PIECE_L = 2'd3;

  typedef enum logic {
    Q_FILL = 1'b0,
    Q_FULL = 1'b1
  } q_state_t;

endpackage

// File: rtl/piece_fifo.sv
// DEPTH-entry circular piece buffer with head and head+1 read ports; writes land one edge later.
// Caller must qualify push/pop (no push when full, no pop when empty); this block does not guard.
module piece_fifo #(
  parameter int DEPTH   = 4,
  parameter int PIECE_W = 2,
  parameter int CW      = $clog2(DEPTH + 1)
) (
  input  logic               clka,
  input  logic               restart,
  input  logic               push,
  input  logic               pop,
  input  logic [PIECE_W-1:0] wr_dat,
  output logic [PIECE_W-1:0] head,
  output logic [PIECE_W-1:0] preview,
  output logic [CW-1:0]      count
);

  localparam int AW = $clog2(DEPTH);

  logic [PIECE_W-1:0] mem [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr_nxt;

  // Power-of-two depth: natural pointer overflow is the modulo-DEPTH wrap.
  assign rd_ptr_nxt = rd_ptr + AW'(1);

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr_nxt;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head    = (count != '0)      ? mem[rd_ptr]     : '0;
  assign preview = (count >= CW'(2))  ? mem[rd_ptr_nxt] : '0;

endmodule

// File: rtl/piece_queue.sv
// Next-piece queue: filters over-long repeats from the RNG, hands the head out on take; 1-cycle push-to-head.
// Backpressure: when full the RNG sample is dropped (push uses pre-pop occupancy); take on empty is ignored.
module piece_queue #(
  parameter int DEPTH      = 4,
  parameter int PIECE_W    = piece_pkg::PIECE_W,
  parameter int MAX_REPEAT = 2
) (
  input  logic                         clka,
  input  logic                         restart,
  input  logic [PIECE_W-1:0]           random,
  input  logic                         take,
  output logic [PIECE_W-1:0]           head_piece,
  output logic                         head_valid,
  output logic [PIECE_W-1:0]           preview_piece,
  output logic                         preview_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  import piece_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = $clog2(MAX_REPEAT + 1);

  q_state_t           state;
  q_state_t           state_nxt;
  logic [PIECE_W-1:0] last_piece;
  logic               last_valid;
  logic [RW-1:0]      run_len;
  logic               rep_match;
  logic               reject;
  logic               push;
  logic               pop;

  assign rep_match = last_valid && (random == last_piece);
  assign reject    = rep_match && (run_len == RW'(MAX_REPEAT));
  assign push      = (state == Q_FILL) && !reject;
  assign pop       = take && head_valid;

  piece_fifo #(
    .DEPTH   (DEPTH),
    .PIECE_W (PIECE_W),
    .CW      (CW)
  ) u_fifo (
    .clka    (clka),
    .restart (restart),
    .push    (push),
    .pop     (pop),
    .wr_dat  (random),
    .head    (head_piece),
    .preview (preview_piece),
    .count   (count)
  );

  assign head_valid    = (count != '0);
  assign preview_valid = (count >= CW'(2));

  always_ff @(posedge clka or posedge restart) begin
    if (restart) state <= Q_FILL;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      Q_FILL:  if (push && !pop && (count == CW'(DEPTH - 1))) state_nxt = Q_FULL;
      Q_FULL:  if (pop) state_nxt = Q_FILL;
      default: state_nxt = Q_FILL;
    endcase
  end

  // Repeat history only moves on accepted pushes and outlives pops.
  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      last_piece <= '0;
      last_valid <= 1'b0;
      run_len    <= '0;
    end else if (push) begin
      last_piece <= random;
      last_valid <= 1'b1;
      run_len    <= rep_match ? run_len + RW'(1) : RW'(1);
    end
  end

endmodule

// File: tb/tb_piece_queue.sv
// Directed scenarios followed by randomized traffic, checked against a queue-based reference model.
module tb_piece_queue;

  localparam int DEPTH = 4;
  localparam int MAXR  = 2;
  localparam int CW    = 3;

  logic          clka    = 1'b0;
  logic          restart = 1'b1;
  logic [1:0]    random  = 2'd0;
  logic          take    = 1'b0;
  logic [1:0]    head_piece;
  logic          head_valid;
  logic [1:0]    preview_piece;
  logic          preview_valid;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  int mq[$];
  int last_p;
  bit last_v;
  int run;

  always #5 clka = ~clka;

  piece_queue #(.DEPTH(DEPTH), .PIECE_W(2), .MAX_REPEAT(MAXR)) dut (
    .clka          (clka),
    .restart       (restart),
    .random        (random),
    .take          (take),
    .head_piece    (head_piece),
    .head_valid    (head_valid),
    .preview_piece (preview_piece),
    .preview_valid (preview_valid),
    .count         (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    check({tag, ".count"},         32'(count),         32'(n));
    check({tag, ".head_valid"},    32'(head_valid),    32'(n > 0));
    check({tag, ".head_piece"},    32'(head_piece),    32'((n > 0) ? mq[0] : 0));
    check({tag, ".preview_valid"}, 32'(preview_valid), 32'(n > 1));
    check({tag, ".preview_piece"}, 32'(preview_piece), 32'((n > 1) ? mq[1] : 0));
  endtask

  task automatic model_clear();
    mq.delete();
    last_p = 0;
    last_v = 0;
    run    = 0;
  endtask

  // One clock edge of the queue rules: push decided on the occupancy before any pop.
  task automatic model_edge(input int r, input bit t);
    int pre;
    bit match;
    bit do_push;
    pre     = mq.size();
    do_push = 0;
    if (pre < DEPTH) begin
      match = last_v && (r == last_p);
      if (!(match && run == MAXR)) begin
        do_push = 1;
        run     = match ? run + 1 : 1;
        last_p  = r;
        last_v  = 1;
      end
    end
    if (t && pre > 0) void'(mq.pop_front());
    if (do_push) mq.push_back(r);
  endtask

  // Called just after a negedge; returns at the following negedge.
  task automatic step(input int r, input bit t, input string tag);
    random = 2'(r);
    take   = t;
    @(posedge clka);
    model_edge(r, t);
    #1;
    check_all(tag);
    @(negedge clka);
  endtask

  // Asynchronous reset pulse placed between edges.
  task automatic do_reset(input string tag);
    restart = 1'b1;
    take    = 1'b0;
    #1;
    model_clear();
    check_all(tag);
    #2;
    restart = 1'b0;
  endtask

  initial begin
    model_clear();
    #3;
    check_all("reset");
    @(negedge clka);
    restart = 1'b0;

    // Fill from empty with distinct pieces.
    for (int i = 0; i < 4; i++) step(i, 0, "t1_fill");
    step(2, 0, "t1_full_hold");

    // Repeat filter: third and fourth 2 are dropped, then 3 is accepted.
    do_reset("t2_rst");
    for (int i = 0; i < 4; i++) step(2, 0, "t2_rep");
    step(3, 0, "t2_new");
    step(3, 0, "t2_run1");

    // Take while full: push blocked that edge, slot refilled on the next.
    do_reset("t3_rst");
    for (int i = 0; i < 4; i++) step(i, 0, "t3_fill");
    step(1, 1, "t3_take_full");
    step(1, 0, "t3_refill");

    // Push and pop on the same edge.
    do_reset("t4_rst");
    step(3, 0, "t4_a");
    step(0, 0, "t4_b");
    step(2, 1, "t4_pushpop");

    // Drain with every push rejected, then take on empty.
    do_reset("t5_rst");
    step(1, 0, "t5_a");
    step(1, 0, "t5_b");
    for (int i = 0; i < 3; i++) step(1, 1, "t5_drain");
    step(1, 1, "t5_empty_take");
    step(3, 0, "t5_after");
    step(0, 0, "t5_after2");

    // Async reset mid-operation clears repeat history.
    do_reset("t6_rst");
    step(1, 0, "t6_a");
    step(2, 0, "t6_b");
    step(2, 0, "t6_c");
    step(2, 0, "t6_rej");
    do_reset("t6_async");
    step(2, 0, "t6_refill");

    // Ten pushes, nine pops across pointer wrap.
    do_reset("t7_rst");
    for (int i = 0; i < 10; i++) step(i % 4, i > 0, "t7_wrap");

    // Randomized traffic with occasional resets.
    do_reset("rnd_rst");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(49) == 0) do_reset("rnd_reset");
      else step(int'($urandom_range(3)), $urandom_range(9) < 4, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
